// File: rtl/rc4_stream_xor.sv
// rc4_stream_xor: XORs buffered RC4 keystream blocks onto a valid/ready byte stream.
// Define RC4_STREAM_PREFETCH_EN for a second keystream buffer (zero-bubble block refill).
module rc4_stream_xor #(
  parameter int NUMS_OF_BYTES = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       go,
  output logic                       ks_start,
  input  logic                       ks_done,
  input  logic [NUMS_OF_BYTES*8-1:0] ks_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [7:0]                 in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [7:0]                 out_data,
  output logic                       busy
);

  localparam int W  = NUMS_OF_BYTES * 8;
  localparam int IW = (NUMS_OF_BYTES > 2) ? $clog2(NUMS_OF_BYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUMS_OF_BYTES - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RUN} state_t;

  state_t        state;
  state_t        state_nx;
  logic [W-1:0]  kbuf0;
  logic [IW-1:0] idx;
  logic          accept;
  logic          wrap;

  assign in_ready = (state == RUN) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign wrap     = accept && (idx == LAST);
  assign busy     = (state != IDLE);

`ifdef RC4_STREAM_PREFETCH_EN
  logic [W-1:0] kbuf1;
  logic         kbuf1_v;
  logic         pend;
  logic         arm;
  logic         fire;
  logic         take;
  logic         direct;

  assign fire   = arm && !kbuf1_v && !pend;
  assign take   = pend && ks_done;
  // refill arriving on the exhausting accept goes straight to kbuf0
  assign direct = wrap && !kbuf1_v && take;
`endif

  always_ff @(posedge clk) begin
    if (rst_n) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ks_start = 1'b0;
    unique case (state)
      IDLE: if (go) state_nx = REQ;
      REQ: begin
        ks_start = 1'b1;
        state_nx = WAIT;
      end
      WAIT: if (ks_done) state_nx = RUN;
      RUN: begin
`ifdef RC4_STREAM_PREFETCH_EN
        if (wrap && !kbuf1_v && !take)
          state_nx = pend ? WAIT : REQ;
`else
        if (wrap) state_nx = REQ;
`endif
      end
      default: state_nx = IDLE;
    endcase
`ifdef RC4_STREAM_PREFETCH_EN
    if (fire) ks_start = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      kbuf0     <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (state == WAIT && ks_done) begin
        kbuf0 <= ks_data;
        idx   <= '0;
      end
      if (accept) begin
        out_data  <= in_data ^ kbuf0[int'(idx)*8 +: 8];
        out_valid <= 1'b1;
        idx       <= wrap ? '0 : idx + 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
`ifdef RC4_STREAM_PREFETCH_EN
      if (wrap && kbuf1_v)
        kbuf0 <= kbuf1;
      else if (direct)
        kbuf0 <= ks_data;
`endif
    end
  end

`ifdef RC4_STREAM_PREFETCH_EN
  always_ff @(posedge clk) begin
    if (rst_n) begin
      kbuf1   <= '0;
      kbuf1_v <= 1'b0;
      pend    <= 1'b0;
      arm     <= 1'b0;
    end else begin
      // every (re)entry into a fresh block arms one prefetch request
      arm <= (state == WAIT && ks_done) ||
             (state == RUN && wrap && (kbuf1_v || take));
      if (ks_start)  pend <= 1'b1;
      else if (take) pend <= 1'b0;
      if (wrap && kbuf1_v) begin
        kbuf1_v <= 1'b0;
      end else if (state == RUN && take && !direct) begin
        kbuf1   <= ks_data;
        kbuf1_v <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rc4_stream_xor.sv
// tb_rc4_stream_xor: directed bench with a stream-level XOR model
// (output stream = input stream ^ concatenated keystream bytes).
module tb_rc4_stream_xor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        go = 1'b0;
  logic        ks_start;
  logic        ks_done;
  logic [31:0] ks_data;
  logic        ks_real;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'h00;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_data;
  logic        busy;

  int cnt = 0;
  int fails = 0;

  int          epoch = 0;
  int          gen_lat = 1;
  int          spur_req = 0;
  logic [31:0] spur_data = 32'h0;
  logic [31:0] blk_tab [8];

  logic [7:0] ks_q [$];
  logic [7:0] exp_q [$];
  logic [7:0] got [$];
  int         acc_cyc [$];
  int         cyc = 0;
  int         ks_pulses = 0;

  rc4_stream_xor #(.NUMS_OF_BYTES(4)) dut (
    .clk(clk), .rst_n(rst_n), .go(go),
    .ks_start(ks_start), .ks_done(ks_done), .ks_data(ks_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    cnt++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // keystream generator: answers each request after gen_lat cycles
  initial begin
    int rd = 0;
    int ep = 0;
    int sp = 0;
    ks_done = 1'b0;
    ks_data = '0;
    ks_real = 1'b0;
    forever begin
      @(negedge clk);
      if (ep != epoch) begin
        ep = epoch;
        rd = 0;
      end
      if (sp != spur_req) begin
        sp = spur_req;
        @(posedge clk); #1;
        ks_done = 1'b1; ks_real = 1'b0; ks_data = spur_data;
        @(posedge clk); #1;
        ks_done = 1'b0;
      end else if (ks_start) begin
        repeat (gen_lat) @(posedge clk);
        #1;
        if (ep == epoch) begin
          ks_done = 1'b1; ks_real = 1'b1; ks_data = blk_tab[rd];
          rd++;
          @(posedge clk); #1;
          ks_done = 1'b0; ks_real = 1'b0;
        end
      end
    end
  end

  // monitor and stream model, sampled on the falling edge
  initial begin
    logic       acc_prev = 1'b0;
    logic       hold_v = 1'b0;
    logic [7:0] hold_d = 8'h0;
    logic       ks_prev = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        ks_q.delete();
        exp_q.delete();
        acc_prev = 1'b0;
        hold_v = 1'b0;
        ks_prev = 1'b0;
      end else begin
        if (ks_done && ks_real)
          for (int k = 0; k < 4; k++) ks_q.push_back(ks_data[k*8 +: 8]);
        if (acc_prev) chk("latency_valid", out_valid, 1);
        if (hold_v) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_data", out_data, hold_d);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) chk("spurious_out", 1, 0);
          else chk("out_data", out_data, exp_q.pop_front());
          got.push_back(out_data);
        end
        hold_v = out_valid && !out_ready;
        hold_d = out_data;
        if (in_valid && in_ready) begin
          if (ks_q.size() == 0) chk("stale_key_accept", 1, 0);
          else exp_q.push_back(in_data ^ ks_q.pop_front());
          acc_cyc.push_back(cyc);
          acc_prev = 1'b1;
        end else begin
          acc_prev = 1'b0;
        end
        if (ks_start) begin
          chk("ks_start_single", ks_prev, 0);
          ks_pulses++;
        end
        ks_prev = ks_start;
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b1; go = 1'b0;
    in_valid = 1'b0; in_data = 8'h0; out_ready = 1'b1;
    epoch++;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
  endtask

  task automatic pulse_go();
    go = 1'b1;
    @(posedge clk); #1 go = 1'b0;
    @(negedge clk);
    chk("ks_start_after_go", ks_start, 1);
    chk("busy_after_go", busy, 1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    in_valid = 1'b1;
    in_data = b;
    @(negedge clk);
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) chk("in_ready_timeout", 0, 1);
    @(posedge clk); #1 in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int g0, p0, a0, d;
    logic [7:0] v;
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
    g0 = 0; p0 = 0; a0 = 0; d = 0; v = 0;
  end

  initial begin
    int g0, p0, a0, d;
    // test 1: reset state and first block
    do_reset();
    @(negedge clk);
    chk("rst_ks_start", ks_start, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    #1;
    blk_tab[0] = 32'h40302010; blk_tab[1] = 32'h04030201;
    gen_lat = 1;
    g0 = got.size(); p0 = ks_pulses;
    pulse_go();
    for (int i = 0; i < 4; i++) send_byte(8'h00);
`ifdef RC4_STREAM_PREFETCH_EN
    chk("t1_pulses", ks_pulses - p0, 2);
`else
    chk("t1_pulses", ks_pulses - p0, 1);
`endif
    idle(3);
    chk("t1_out0", got[g0], 8'h10);
    chk("t1_out1", got[g0+1], 8'h20);
    chk("t1_out2", got[g0+2], 8'h30);
    chk("t1_out3", got[g0+3], 8'h40);

    // test 2: nonzero data and block boundary stall
    do_reset();
    blk_tab[0] = 32'h40302010; blk_tab[1] = 32'h04030201;
    gen_lat = 4;
    g0 = got.size(); a0 = acc_cyc.size();
    pulse_go();
    for (int i = 0; i < 5; i++) send_byte(8'h41 + 8'(i));
    idle(3);
    chk("t2_out0", got[g0], 8'h51);
    chk("t2_out1", got[g0+1], 8'h62);
    chk("t2_out2", got[g0+2], 8'h73);
    chk("t2_out3", got[g0+3], 8'h04);
    chk("t2_out4", got[g0+4], 8'h44);
    d = acc_cyc[a0+4] - acc_cyc[a0+3];
`ifndef RC4_STREAM_PREFETCH_EN
    chk("t2_boundary_stall", d >= 2 + gen_lat, 1);
`endif

    // test 3: downstream backpressure
    do_reset();
    blk_tab[0] = 32'h40302010; blk_tab[1] = 32'h04030201;
    gen_lat = 1;
    g0 = got.size();
    pulse_go();
    send_byte(8'h00);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h00;
    repeat (3) begin
      @(negedge clk);
      chk("t3_held_data", out_data, 8'h10);
      chk("t3_stall_ready", in_ready, 0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send_byte(8'h00);
    idle(3);
    chk("t3_count", got.size() - g0, 4);
    chk("t3_out0", got[g0], 8'h10);
    chk("t3_out1", got[g0+1], 8'h20);
    chk("t3_out3", got[g0+3], 8'h40);

    // test 4: reset mid-block, late/spurious ks_done ignored
    do_reset();
    blk_tab[0] = 32'h40302010; blk_tab[1] = 32'h04030201;
    pulse_go();
    send_byte(8'h00);
    send_byte(8'h00);
    do_reset();
    @(negedge clk);
    chk("t4_rst_out_valid", out_valid, 0);
    chk("t4_rst_busy", busy, 0);
    #1;
    blk_tab[0] = 32'hDDCCBBAA;
    spur_data = 32'h55555555;
    spur_req++;
    idle(4);
    @(negedge clk);
    chk("t4_spur_busy", busy, 0);
    chk("t4_spur_ready", in_ready, 0);
    #1;
    g0 = got.size();
    pulse_go();
    send_byte(8'h00);
    idle(3);
    chk("t4_out0", got[g0], 8'hAA);

    // test 5/6: continuous 12-byte stream, generator latency 3
    do_reset();
    blk_tab[0] = 32'h11223344; blk_tab[1] = 32'hA5A55A5A;
    blk_tab[2] = 32'h0F1E2D3C; blk_tab[3] = 32'h99887766;
    gen_lat = 3;
    g0 = got.size(); a0 = acc_cyc.size(); p0 = ks_pulses;
    pulse_go();
    for (int i = 0; i < 12; i++) send_byte(8'(i * 17 + 3));
`ifdef RC4_STREAM_PREFETCH_EN
    chk("t5_pulses", ks_pulses - p0, 4);
`else
    chk("t5_pulses", ks_pulses - p0, 3);
`endif
    for (int k = 1; k < 12; k++) begin
      d = acc_cyc[a0+k] - acc_cyc[a0+k-1];
`ifdef RC4_STREAM_PREFETCH_EN
      chk("t5_no_bubble", d, 1);
`else
      if (k % 4 == 0) chk("t6_boundary_gap", d >= 2 + gen_lat, 1);
      else chk("t6_in_block", d, 1);
`endif
    end
    idle(3);
    chk("t5_count", got.size() - g0, 12);
    chk("t5_out0", got[g0], 8'h03 ^ 8'h44);
    chk("t5_out4", got[g0+4], 8'h47 ^ 8'h5A);
    chk("t5_out11", got[g0+11], 8'hBE ^ 8'h0F);

    $display("End of test - %0d assertions evaluated, %0d failures",
             cnt, fails);
    $finish;
  end

endmodule
